// File: rtl/alu_issue_ctrl.sv
// Purpose: issue stage for the 4-bit combinational ALU; holds the register file, registers operands/opcode, writes results back.
// Latency: accept edge N -> writeback edge N+1; res_valid high for the cycle after writeback; one instruction per 2 cycles.
// Backpressure: in_ready = (state == IDLE); the source must hold in_instr/in_valid until in_ready is seen.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_instr     instruction handshake, in_instr = {op, rd, rs1, rs2}
//   wr_en/wr_addr/wr_data          direct register-file write (initialisation)
//   clr_flags                      clears ov_sticky
//   alu_a/alu_b/alu_sel            registered operands/opcode to the ALU
//   alu_out/alu_ov                 combinational ALU return
//   res_valid/res_data/res_ov/res_zero/ov_sticky   writeback results and flags
module alu_issue_ctrl #(
    parameter int DW = 4,
    parameter int AW = 2,
    parameter int IW = 3 + 3 * AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clr_flags,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_ov,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          res_ov,
    output logic          res_zero,
    output logic          ov_sticky
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] rf [DEPTH];
    logic [AW-1:0] rd_q;

    logic [2:0]    dec_op;
    logic [AW-1:0] dec_rd;
    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic          accept;
    logic          wb;

    assign dec_op  = in_instr[IW-1 -: 3];
    assign dec_rd  = in_instr[3*AW-1 -: AW];
    assign dec_rs1 = in_instr[2*AW-1 -: AW];
    assign dec_rs2 = in_instr[AW-1:0];

    // Gated with rst_n so the source never sees ready while the block is held in reset.
    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign wb       = (state_q == EXEC);
    assign res_zero = (res_data == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are read from the pre-edge register file, so a same-cycle
    // direct write is not visible to the instruction being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            alu_a   <= rf[dec_rs1];
            alu_b   <= rf[dec_rs2];
            alu_sel <= dec_op;
            rd_q    <= dec_rd;
        end
    end

    // Writeback is assigned after the direct write so it wins on an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                rf[wr_addr] <= wr_data;
            end
            if (wb) begin
                rf[rd_q] <= alu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ov    <= 1'b0;
            ov_sticky <= 1'b0;
        end else begin
            res_valid <= wb;
            if (wb) begin
                res_data <= alu_out;
                res_ov   <= alu_ov;
            end
            // A new overflow takes priority over a clear at the same edge.
            if (wb && alu_ov) begin
                ov_sticky <= 1'b1;
            end else if (clr_flags) begin
                ov_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose: self-checking bench for alu_issue_ctrl with a behavioural 4-bit ALU attached.
// Latency: expected writebacks are queued at issue and popped whenever res_valid is seen.
// Backpressure: instructions are held until in_ready is sampled high, bounded by a cycle budget.
module tb_alu_issue_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int IW = 3 + 3 * AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_instr = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_flags = 1'b0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_out;
    logic          alu_ov;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ov;
    logic          res_zero;
    logic          ov_sticky;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ov;
        logic          st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   pops = 0;
    int   pushes = 0;

    alu_issue_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_flags (clr_flags),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_ov    (alu_ov),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ov    (res_ov),
        .res_zero  (res_zero),
        .ov_sticky (ov_sticky)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: carry/borrow out on add/sub, no overflow otherwise.
    logic [DW:0] wide;
    always_comb begin
        wide    = '0;
        alu_out = '0;
        alu_ov  = 1'b0;
        case (alu_sel)
            3'b000: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = wide[DW-1:0]; alu_ov = wide[DW]; end
            3'b001: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = wide[DW-1:0]; alu_ov = wide[DW]; end
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            3'b101: alu_out = alu_a << alu_b;
            3'b110: alu_out = alu_a >> alu_b;
            default: alu_out = {alu_a[DW-2:0], alu_a[DW-1]};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every res_valid pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("res_data", 32'(res_data), 32'(e.d));
                    chk("res_ov", 32'(res_ov), 32'(e.ov));
                    chk("res_zero", 32'(res_zero), 32'(e.d == '0));
                    chk("ov_sticky", 32'(ov_sticky), 32'(e.st));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic push, input logic [DW-1:0] d,
                         input logic ov, input logic st, input logic we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int n = 0;
        if (push) begin
            exp_q.push_back('{d: d, ov: ov, st: st});
            pushes++;
        end
        in_instr = {op, rd, rs1, rs2};
        in_valid = 1'b1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic ex(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input logic [DW-1:0] d, input logic ov, input logic st);
        issue(op, rd, rs1, rs2, 1'b1, d, ov, st, 1'b0, '0, '0);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_res_zero", 32'(res_zero), 1);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_ov_sticky", 32'(ov_sticky), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // 1: add with overflow
        wr(2'd0, 4'd9);
        wr(2'd1, 4'd8);
        ex(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd1, 1'b1, 1'b1);
        chk("t1_alu_a", 32'(alu_a), 9);
        chk("t1_alu_b", 32'(alu_b), 8);
        chk("t1_alu_sel", 32'(alu_sel), 0);
        chk("t1_exec_not_ready", 32'(in_ready), 0);
        settle();
        ex(OP_OR, 2'd2, 2'd2, 2'd2, 4'd1, 1'b0, 1'b1);
        settle();

        // 2: subtract with borrow, clear, xor to zero
        wr(2'd0, 4'd3);
        wr(2'd1, 4'd5);
        ex(OP_SUB, 2'd3, 2'd0, 2'd1, 4'b1110, 1'b1, 1'b1);
        settle();
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        @(negedge clk);
        chk("t2_sticky_cleared", 32'(ov_sticky), 0);
        @(posedge clk); #1;
        ex(OP_XOR, 2'd0, 2'd3, 2'd3, 4'd0, 1'b0, 1'b0);
        settle();

        // 3: rotate, back-to-back
        wr(2'd1, 4'b1001);
        ex(OP_ROL, 2'd1, 2'd1, 2'd1, 4'b0011, 1'b0, 1'b0);
        ex(OP_ROL, 2'd1, 2'd1, 2'd1, 4'b0110, 1'b0, 1'b0);
        chk("t3_second_operand", 32'(alu_a), 4'b0011);
        settle();

        // 4: backpressure with two held instructions (r0=0, r1=6)
        exp_q.push_back('{d: 4'd12, ov: 1'b0, st: 1'b0}); pushes++;
        exp_q.push_back('{d: 4'd6,  ov: 1'b0, st: 1'b0}); pushes++;
        in_instr = {OP_ADD, 2'd0, 2'd1, 2'd1};
        in_valid = 1'b1;
        @(negedge clk); chk("t4_ready0", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_instr = {OP_SUB, 2'd2, 2'd0, 2'd1};
        @(negedge clk); chk("t4_ready1", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk); chk("t4_ready2", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); chk("t4_ready3", 32'(in_ready), 0);
        settle();

        // 5a: direct write to rd at writeback edge loses
        wr(2'd0, 4'd9);
        wr(2'd1, 4'd8);
        ex(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd1, 1'b1, 1'b1);
        wr(2'd2, 4'd7);
        @(posedge clk); #1;
        ex(OP_OR, 2'd3, 2'd2, 2'd2, 4'd1, 1'b0, 1'b1);
        settle();

        // 5b: direct write in the acceptance cycle; operand sees old value
        issue(OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 2'd0, 4'd5);
        chk("t5_old_operand", 32'(alu_a), 9);
        settle();
        ex(OP_OR, 2'd3, 2'd0, 2'd0, 4'd5, 1'b0, 1'b1);
        settle();

        // 6: reset during EXEC abandons the instruction
        issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", 32'(in_ready), 0);
        chk("t6_rst_res_valid", 32'(res_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", 32'(in_ready), 1);
        chk("t6_res_valid_after", 32'(res_valid), 0);
        chk("t6_sticky_after", 32'(ov_sticky), 0);
        chk("t6_alu_a_after", 32'(alu_a), 0);
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            ex(OP_OR, 2'(r), 2'(r), 2'(r), 4'd0, 1'b0, 1'b0);
            settle();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("writeback_count", 32'(pops), 32'(pushes));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
